// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared FSM state type and default sizing for the data-memory responder
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DEPTH_WORDS_DEFAULT = 256;
  localparam int DMEM_WAIT_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with one synchronous write port and one registered read port
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEFAULT,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  // no reset: contents must survive a responder reset
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data-memory responder: IDLE/WAIT/RESP FSM, wait counter, address checking
// Define DMEM_RESPONDER_ERR_CHECK_EN to reject misaligned and out-of-range accesses with rsp_err.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEFAULT,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int N = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t state;
  logic [3:0]  wait_cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;

  logic        exec;
  logic        exec_write;
  logic        exec_err;
  logic [31:0] exec_addr;
  logic [31:0] exec_wdata;
  logic [31:0] rd_data;

  // zero-wait accesses execute on the acceptance edge straight from the request inputs
  assign exec       = (state == ST_IDLE && req_valid && NO_WAIT) ||
                      (state == ST_WAIT && wait_cnt == 4'd0);
  assign exec_write = (state == ST_IDLE) ? req_write : cap_write;
  assign exec_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
  assign exec_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
  assign exec_err = (exec_addr[1:0] != 2'b00) || (exec_addr >= 32'(4 * DEPTH_WORDS));
`else
  logic unused_addr_bits;
  assign exec_err         = 1'b0;
  assign unused_addr_bits = ^{exec_addr[31:N+2], exec_addr[1:0]};
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock  (clock),
    .wr_en  (exec && exec_write && !exec_err && reset),
    .wr_addr(exec_addr[N+1:2]),
    .wr_data(exec_wdata),
    .rd_en  (exec && !exec_write && !exec_err),
    .rd_addr(exec_addr[N+1:2]),
    .rd_data(rd_data)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            ready_q   <= 1'b0;
            if (NO_WAIT) begin
              state   <= ST_RESP;
              valid_q <= 1'b1;
              err_q   <= exec_err;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state   <= ST_RESP;
            valid_q <= 1'b1;
            err_q   <= exec_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = (valid_q && !cap_write && !err_q) ? rd_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder (zero-wait and two-wait instances) against a transaction model
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int NI = 2;
  localparam int WC [NI] = '{0, 2};

  logic        clock;
  logic        reset     [NI];
  logic        req_valid [NI];
  logic        req_write [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC[0])) dut0 (
    .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC[1])) dut1 (
    .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // model: memory image plus edges elapsed since acceptance (0 = idle)
  logic [31:0] mem_m   [NI][DEPTH];
  int          age     [NI] = '{0, 0};
  bit          p_write [NI];
  logic [31:0] p_addr  [NI];
  logic [31:0] p_wdata [NI];
  logic [31:0] e_rdata [NI];
  bit          e_err   [NI];

  function automatic bit addr_err(input logic [31:0] a);
`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h", name, i, act, exp);
    end
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < NI; i++) begin
      int prev;
      prev = age[i];
      if (!reset[i]) age[i] = 0;
      else if (age[i] == 0) begin
        if (req_valid[i]) begin
          p_write[i] = req_write[i];
          p_addr[i]  = req_addr[i];
          p_wdata[i] = req_wdata[i];
          age[i] = 1;
        end
      end else if (age[i] <= WC[i]) age[i] = age[i] + 1;
      else if (rsp_ready[i]) age[i] = 0;
      if (age[i] == WC[i] + 1 && prev != age[i]) begin
        e_err[i]   = addr_err(p_addr[i]);
        e_rdata[i] = 32'd0;
        if (!e_err[i]) begin
          if (p_write[i]) mem_m[i][widx(p_addr[i])] = p_wdata[i];
          else e_rdata[i] = mem_m[i][widx(p_addr[i])];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        check("req_ready", i, 32'(req_ready[i]), 32'(age[i] == 0));
        check("rsp_valid", i, 32'(rsp_valid[i]), 32'(age[i] > WC[i]));
        check("rsp_rdata", i, rsp_rdata[i], (age[i] > WC[i]) ? e_rdata[i] : 32'd0);
        check("rsp_err",   i, 32'(rsp_err[i]), (age[i] > WC[i]) ? 32'(e_err[i]) : 32'd0);
      end
    end
  end

  task automatic scr(input int i);
    req_valid[i] = 1'($urandom_range(0, 1));
    req_write[i] = 1'($urandom_range(0, 1));
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
  endtask

  task automatic do_req(input int i, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit scramble, input int hold, output int lat,
                        output logic [31:0] rd_first, output logic [31:0] rd_last, output bit er);
    int n;
    @(negedge clock);
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = addr; req_wdata[i] = wdata;
    rsp_ready[i] = 1'b0;
    @(negedge clock);
    req_valid[i] = 1'b0;
    if (scramble) scr(i);
    lat = 1;
    n = 0;
    while (rsp_valid[i] !== 1'b1 && n < 40) begin
      @(negedge clock);
      if (scramble) scr(i);
      lat++;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL timeout inst%0d: rsp_valid got %b expected 1 within 40 cycles", i, rsp_valid[i]);
    end
    rd_first = rsp_rdata[i];
    er = rsp_err[i];
    repeat (hold) begin
      @(negedge clock);
      if (scramble) scr(i);
    end
    rd_last = rsp_rdata[i];
    rsp_ready[i] = 1'b1;
    @(negedge clock);
    rsp_ready[i] = 1'b0;
    req_valid[i] = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] r1, r2, a;
    bit er;
    int i;

    for (int k = 0; k < NI; k++) begin
      reset[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = 32'd0; req_wdata[k] = 32'd0; rsp_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clock);
    chk_on = 1'b1;
    for (int k = 0; k < NI; k++) begin
      check("reset_req_ready", k, 32'(req_ready[k]), 32'd1);
      check("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
      check("reset_rsp_rdata", k, rsp_rdata[k], 32'd0);
      check("reset_rsp_err",   k, 32'(rsp_err[k]), 32'd0);
      reset[k] = 1'b1;
    end

    for (int k = 0; k < NI; k++)
      for (int w = 0; w < DEPTH; w++)
        do_req(k, 1'b1, 32'(w * 4), $urandom, 1'b0, 0, lat, r1, r2, er);

    do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, lat, r1, r2, er);
    check("store_latency", 1, 32'(lat), 32'd3);
    check("store_rdata",   1, r1, 32'd0);
    check("store_err",     1, 32'(er), 32'd0);
    do_req(1, 1'b0, 32'h10, 32'd0, 1'b0, 5, lat, r1, r2, er);
    check("load_latency",    1, 32'(lat), 32'd3);
    check("load_rdata",      1, r1, 32'hDEADBEEF);
    check("load_rdata_held", 1, r2, 32'hDEADBEEF);

    do_req(0, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, 0, lat, r1, r2, er);
    do_req(0, 1'b0, 32'h0, 32'd0, 1'b0, 3, lat, r1, r2, er);
    check("zw_latency", 0, 32'(lat), 32'd1);
    check("zw_rdata",   0, r2, 32'hA5A5A5A5);

    do_req(1, 1'b1, 32'h44, 32'h77777777, 1'b1, 2, lat, r1, r2, er);
    do_req(1, 1'b0, 32'h44, 32'd0, 1'b1, 2, lat, r1, r2, er);
    check("captured_rdata", 1, r1, 32'h77777777);

    do_req(1, 1'b1, 32'h0, 32'h11111111, 1'b0, 0, lat, r1, r2, er);
`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    do_req(1, 1'b1, 32'h13, 32'hBAD0BAD0, 1'b0, 0, lat, r1, r2, er);
    check("misaligned_err", 1, 32'(er), 32'd1);
    do_req(1, 1'b1, 32'h400, 32'hBAD1BAD1, 1'b0, 0, lat, r1, r2, er);
    check("range_err", 1, 32'(er), 32'd1);
    do_req(1, 1'b0, 32'h10, 32'd0, 1'b0, 0, lat, r1, r2, er);
    check("after_err_0x10", 1, r1, 32'hDEADBEEF);
    do_req(1, 1'b0, 32'h0, 32'd0, 1'b0, 0, lat, r1, r2, er);
    check("after_err_0x0", 1, r1, 32'h11111111);
`else
    do_req(1, 1'b1, 32'h400, 32'h55AA55AA, 1'b0, 0, lat, r1, r2, er);
    check("wrap_err", 1, 32'(er), 32'd0);
    do_req(1, 1'b0, 32'h0, 32'd0, 1'b0, 0, lat, r1, r2, er);
    check("wrap_rdata", 1, r1, 32'h55AA55AA);
`endif

    do_req(1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 0, lat, r1, r2, er);
    @(negedge clock);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
    @(negedge clock);
    req_valid[1] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clock);
    reset[1] = 1'b1;
    check("wait_reset_ready", 1, 32'(req_ready[1]), 32'd1);
    check("wait_reset_valid", 1, 32'(rsp_valid[1]), 32'd0);
    do_req(1, 1'b0, 32'h20, 32'd0, 1'b0, 0, lat, r1, r2, er);
    check("wait_reset_nowrite", 1, r1, 32'hCAFEF00D);

    for (int t = 0; t < 200; t++) begin
      i = t % NI;
      case ($urandom_range(0, 7))
        0: a = 32'($urandom_range(0, 4 * DEPTH - 1));
        1: a = $urandom;
        default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      do_req(i, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), lat, r1, r2, er);
      check("rand_latency", i, 32'(lat), 32'(WC[i] + 1));
    end

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, storage depth in 32-bit words (power of two, 4..65536).
REQ-002 Parameter WAIT_CYCLES, default 2, extra access latency in cycles (0..15).
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous reset, active-low, sampled on rising clock edge.
REQ-005 req_valid  input  1  CPU presents a data-memory request.
REQ-006 req_write  input  1  1 = store word, 0 = load word.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  CPU accepts the response this cycle.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errored accesses.
REQ-013 rsp_err  output  1  access rejected (misaligned or out of range).

Function
REQ-014 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: on req_valid=1, capture req_write/req_addr/req_wdata and move to WAIT, or straight to RESP if WAIT_CYCLES=0.
REQ-016 WAIT: a down-counter loaded with WAIT_CYCLES-1 on acceptance decrements each cycle; at 0 the access executes and the FSM moves to RESP.
REQ-017 Access execution: stores write the captured data at word index addr[N+1:2] (N=log2 DEPTH_WORDS); loads register that word into rsp_rdata.
REQ-018 Latency: request accepted at edge k; rsp_valid SHALL be 1 after edge k+WAIT_CYCLES+1.
REQ-019 RESP: rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready=1; on that edge return to IDLE (no same-cycle new acceptance).
REQ-020 Captured request fields SHALL NOT change while not in IDLE, regardless of input activity.
REQ-021 Stores SHALL return rsp_rdata=0, rsp_err=0 on success.
REQ-022 rsp_valid SHALL be 0 in IDLE and WAIT; rsp_rdata SHALL be 0 whenever rsp_valid=0.
REQ-023 Storage contents SHALL persist across requests; back-to-back store then load to the same word returns the stored value.

Reset
REQ-024 reset=0 at an edge: FSM to IDLE, counter to 0, req_ready=1 after the edge, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-025 Reset during WAIT SHALL abandon the access with no write; reset during RESP discards the response (a store already committed stays committed).
REQ-026 Storage array SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro DMEM_RESPONDER_ERR_CHECK_EN defined: accesses with req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS complete with normal latency, rsp_err=1, rsp_rdata=0, and no write.
REQ-028 Macro undefined: rsp_err tied 0, addr[1:0] and bits above N+1 ignored (address wraps modulo 4*DEPTH_WORDS).

Structure
REQ-029 FSM state encoding type and the WAIT_CYCLES/DEPTH_WORDS defaults SHALL live in shared package mips_pkg.
REQ-030 Storage SHALL be a sub-module dmem_array (one synchronous write port, one registered read port); FSM, counter and error check stay in dmem_responder.

Verification
REQ-031 Reset, then store 0xDEADBEEF to 0x10 with WAIT_CYCLES=2 -> req_ready drops after accept, rsp_valid rises 3 edges later, rsp_err=0, rsp_rdata=0.
REQ-032 Load from 0x10 after REQ-031 -> rsp_rdata=0xDEADBEEF at latency 3; holding rsp_ready=0 for 5 cycles keeps rsp_valid=1 and data stable.
REQ-033 WAIT_CYCLES=0, load 0x0 -> rsp_valid after exactly 1 edge; req_ready=0 until the edge where rsp_ready=1.
REQ-034 With DMEM_RESPONDER_ERR_CHECK_EN: store to 0x13 and to 0x400 (DEPTH_WORDS=256) -> rsp_err=1 both; following loads of 0x10 and 0x0 unchanged. Without macro: store to 0x400 overwrites word 0.
REQ-035 Store 0x12345678 to 0x20, assert reset=0 during WAIT -> outputs reset values; subsequent load of 0x20 returns previous contents, not 0x12345678.
REQ-036 Change req_addr/req_wdata every cycle during WAIT -> response reflects only the values captured at acceptance.
